// File: rtl/lagtester_pkg.sv
// Shared types and constants for the lag tester measurement path.
package lagtester_pkg;

   localparam int unsigned LAG_CNT_W = 24;

   typedef enum logic [2:0] {
      IDLE,
      DARK,
      ARM,
      MEASURE,
      CONFIRM,
      COOLDOWN
   } LagState;

endpackage

// File: rtl/lag_stats.sv
// Latency statistics: last/min/max, 16-deep sliding-window sum and average.
module lag_stats
   import lagtester_pkg::*;
#(
   parameter int unsigned CNT_W = LAG_CNT_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             commit_i,
   input  logic [CNT_W-1:0] value_i,
   output logic [CNT_W-1:0] last_o,
   output logic [CNT_W-1:0] min_o,
   output logic [CNT_W-1:0] max_o,
   output logic [CNT_W-1:0] avg_o,
   output logic [4:0]       count_o
);

   logic [CNT_W-1:0] win_q [16];
   logic [3:0]       wp_q;
   logic [CNT_W+3:0] sum_q, sum_d;
   logic [CNT_W-1:0] last_q, min_q, max_q, avg_q;
   logic [CNT_W-1:0] min_d, max_d, avg_d;
   logic [4:0]       cnt_q, cnt_d;

   // Unfilled window slots hold zero, so the same update works while filling.
   always_comb begin
      sum_d = sum_q + {4'b0, value_i} - {4'b0, win_q[wp_q]};
      cnt_d = (cnt_q == 5'd16) ? cnt_q : cnt_q + 5'd1;
      min_d = (cnt_q == 5'd0 || value_i < min_q) ? value_i : min_q;
      max_d = (cnt_q == 5'd0 || value_i > max_q) ? value_i : max_q;
      avg_d = avg_q;
      case (cnt_d)
         5'd1:    avg_d = sum_d[CNT_W-1:0];
         5'd2:    avg_d = sum_d[CNT_W:1];
         5'd4:    avg_d = sum_d[CNT_W+1:2];
         5'd8:    avg_d = sum_d[CNT_W+2:3];
         5'd16:   avg_d = sum_d[CNT_W+3:4];
         default: avg_d = avg_q;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < 16; i++) win_q[i] <= '0;
         wp_q   <= '0;
         sum_q  <= '0;
         last_q <= '0;
         min_q  <= '1;
         max_q  <= '0;
         avg_q  <= '0;
         cnt_q  <= '0;
      end else if (commit_i) begin
         win_q[wp_q] <= value_i;
         wp_q        <= wp_q + 4'd1;
         sum_q       <= sum_d;
         last_q      <= value_i;
         min_q       <= min_d;
         max_q       <= max_d;
         avg_q       <= avg_d;
         cnt_q       <= cnt_d;
      end
   end

   assign last_o  = last_q;
   assign min_o   = min_q;
   assign max_o   = max_q;
   assign avg_o   = avg_q;
   assign count_o = cnt_q;

endmodule

// File: rtl/lag_measure_controller.sv
// Sequences one flash/detect display-lag measurement per cycle and feeds lag_stats.
module lag_measure_controller
   import lagtester_pkg::*;
#(
   parameter int unsigned      CNT_W          = LAG_CNT_W,
   parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = CNT_W'(16_000_000),
   parameter int unsigned      DARK_FRAMES    = 4,
   parameter int unsigned      FLASH_FRAMES   = 2,
   parameter int unsigned      DEBOUNCE       = 64
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             frame_start,
   input  logic             sensor,
   output logic             flash,
   output logic             busy,
   output logic             result_valid,
   output logic             timeout,
   output logic [CNT_W-1:0] last_lag,
   output logic [CNT_W-1:0] min_lag,
   output logic [CNT_W-1:0] max_lag,
   output logic [CNT_W-1:0] avg_lag,
   output logic [4:0]       sample_count
);

   localparam int unsigned DW  = $clog2(DARK_FRAMES + 1);
   localparam int unsigned FW  = $clog2(FLASH_FRAMES + 1);
   localparam int unsigned DBW = $clog2(DEBOUNCE + 1);
   localparam logic [DW-1:0]    DARK_LAST  = DW'(DARK_FRAMES - 1);
   localparam logic [FW-1:0]    FLASH_LAST = FW'(FLASH_FRAMES - 1);
   localparam logic [DBW-1:0]   DEB_LAST   = DBW'(DEBOUNCE - 1);
   localparam logic [CNT_W-1:0] TO_LAST    = TIMEOUT_CYCLES - CNT_W'(1);

   LagState          state_q, state_d;
   logic             s_meta_q, sens_s_q;
   logic [CNT_W-1:0] cnt_q, cnt_d, cand_q, cand_d;
   logic [DW-1:0]    dcnt_q, dcnt_d;
   logic [FW-1:0]    fcnt_q, fcnt_d;
   logic [DBW-1:0]   deb_q, deb_d;
   logic             flash_q, flash_d, rv_q, rv_d, to_q, to_d;
   logic             commit;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cand_d  = cand_q;
      dcnt_d  = dcnt_q;
      fcnt_d  = fcnt_q;
      deb_d   = deb_q;
      flash_d = flash_q;
      rv_d    = 1'b0;
      to_d    = 1'b0;
      commit  = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable) begin
               state_d = DARK;
               dcnt_d  = '0;
            end
         end
         DARK: begin
            if (sens_s_q) begin
               dcnt_d = '0;
            end else if (frame_start) begin
               if (dcnt_q == DARK_LAST) state_d = ARM;
               else dcnt_d = dcnt_q + DW'(1);
            end
         end
         ARM: begin
            if (frame_start) begin
               cnt_d   = '0;
               fcnt_d  = '0;
               flash_d = 1'b1;
               state_d = MEASURE;
            end
         end
         MEASURE, CONFIRM: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (frame_start && flash_q) begin
               fcnt_d = fcnt_q + FW'(1);
               if (fcnt_q == FLASH_LAST) flash_d = 1'b0;
            end
            // Timeout wins over a hit or commit landing in the same cycle.
            if (cnt_q == TO_LAST) begin
               to_d    = 1'b1;
               dcnt_d  = '0;
               state_d = DARK;
            end else if (state_q == MEASURE) begin
               if (sens_s_q) begin
                  cand_d  = cnt_q;
                  deb_d   = DBW'(1);
                  state_d = CONFIRM;
               end
            end else if (!sens_s_q) begin
               state_d = MEASURE;
            end else if (deb_q == DEB_LAST) begin
               commit  = 1'b1;
               rv_d    = 1'b1;
               state_d = COOLDOWN;
            end else begin
               deb_d = deb_q + DBW'(1);
            end
         end
         COOLDOWN: begin
            dcnt_d  = '0;
            state_d = DARK;
         end
         default: state_d = IDLE;
      endcase
      if (!enable && state_q != CONFIRM) state_d = IDLE;
      // Flash is only ever lit while a measurement is in flight.
      if (state_d != MEASURE && state_d != CONFIRM) flash_d = 1'b0;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         s_meta_q <= 1'b0;
         sens_s_q <= 1'b0;
         cnt_q    <= '0;
         cand_q   <= '0;
         dcnt_q   <= '0;
         fcnt_q   <= '0;
         deb_q    <= '0;
         flash_q  <= 1'b0;
         rv_q     <= 1'b0;
         to_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         s_meta_q <= sensor;
         sens_s_q <= s_meta_q;
         cnt_q    <= cnt_d;
         cand_q   <= cand_d;
         dcnt_q   <= dcnt_d;
         fcnt_q   <= fcnt_d;
         deb_q    <= deb_d;
         flash_q  <= flash_d;
         rv_q     <= rv_d;
         to_q     <= to_d;
      end
   end

   lag_stats #(
      .CNT_W(CNT_W)
   ) u_stats (
      .clock   (clock),
      .reset   (reset),
      .commit_i(commit),
      .value_i (cand_q),
      .last_o  (last_lag),
      .min_o   (min_lag),
      .max_o   (max_lag),
      .avg_o   (avg_lag),
      .count_o (sample_count)
   );

   assign flash        = flash_q;
   assign busy         = (state_q != IDLE);
   assign result_valid = rv_q;
   assign timeout      = to_q;

endmodule

// File: tb/tb_lag_measure_controller.sv
// Randomized bench: a precomputed per-cycle timeline model checked against the DUT every cycle.
module tb_lag_measure_controller;

   localparam int     P    = 50;
   localparam int     TO   = 2000;
   localparam int     DEB  = 64;
   localparam int     MAXC = 60000;
   localparam longint ONES = 64'hFF_FFFF;

   logic        clock = 1'b0;
   logic        reset, enable, frame_start, sensor;
   logic        flash, busy, result_valid, timeout;
   logic [23:0] last_lag, min_lag, max_lag, avg_lag;
   logic [4:0]  sample_count;

   lag_measure_controller #(
      .CNT_W         (24),
      .TIMEOUT_CYCLES(24'd2000),
      .DARK_FRAMES   (4),
      .FLASH_FRAMES  (2),
      .DEBOUNCE      (64)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .frame_start (frame_start),
      .sensor      (sensor),
      .flash       (flash),
      .busy        (busy),
      .result_valid(result_valid),
      .timeout     (timeout),
      .last_lag    (last_lag),
      .min_lag     (min_lag),
      .max_lag     (max_lag),
      .avg_lag     (avg_lag),
      .sample_count(sample_count)
   );

   always #5 clock = ~clock;

   bit sraw[MAXC];
   bit en_a[MAXC];
   bit exp_flash[MAXC];
   bit exp_rv[MAXC];
   bit exp_to[MAXC];
   bit exp_busy[MAXC];
   int lag_at[MAXC];

   int ent, lhigh, n_cyc, cyc;
   bit active;
   int checks = 0;
   int errors = 0;

   longint win[$];
   longint m_last = 0, m_min = ONES, m_max = 0, m_avg = 0;
   int     m_n = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic sens_high(input int a, input int b);
      for (int c = a; c <= b; c++) sraw[c] = 1'b1;
   endtask

   task automatic flash_span(input int a, input int b);
      for (int c = a; c <= b; c++) exp_flash[c] = 1'b1;
   endtask

   // Accepted frame: four dark frames counted from DARK entry once the synced sensor is low, then one more.
   function automatic int arm_frame();
      return ((imax(ent, lhigh + 3) + P - 1) / P) * P + 4 * P;
   endfunction

   task automatic plan_meas(input int d, input int g, input bit to_kind, input bit dpulse, input int hl);
      int t, h, r;
      if (dpulse) begin
         sens_high(ent + P + 10, ent + 2 * P + 9);
         lhigh = imax(lhigh, ent + 2 * P + 9);
      end
      t = arm_frame();
      if (to_kind) begin
         r = t + 1 + TO;
         exp_to[r] = 1'b1;
         flash_span(t + 1, imin(t + 2 * P, r - 1));
         ent = r;
      end else begin
         if (g >= 0) sens_high(t + 1 + g, t + 10 + g);
         sens_high(t + 1 + d, t + d + hl);
         lhigh = imax(lhigh, t + d + hl);
         h = t + 3 + d;
         r = h + DEB;
         exp_rv[r] = 1'b1;
         lag_at[r] = d + 2;
         flash_span(t + 1, imin(t + 2 * P, r - 1));
         ent = r + 1;
      end
   endtask

   task automatic build_plan();
      int d, g, t;
      lhigh = -100;
      ent   = 6;
      for (int c = 5; c < MAXC; c++) en_a[c] = 1'b1;
      for (int k = 1; k <= 17; k++) plan_meas(100 * k, -1, 1'b0, 1'b0, 64 + int'($urandom_range(0, 200)));
      plan_meas(300, 200, 1'b0, 1'b0, 150);
      plan_meas(0, -1, 1'b1, 1'b0, 0);
      plan_meas(400, -1, 1'b0, 1'b1, 100);
      for (int k = 0; k < 6; k++) begin
         d = int'($urandom_range(20, 1800));
         g = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, d - 20)) : -1;
         plan_meas(d, g, 1'b0, $urandom_range(0, 3) == 0, 64 + int'($urandom_range(0, 200)));
      end
      t = ent + P + 5;
      for (int c = t; c < t + 20; c++) en_a[c] = 1'b0;
      ent = t + 21;
      for (int c = 1; c < MAXC; c++) exp_busy[c] = en_a[c - 1];
      t = arm_frame();
      sens_high(t + 151, t + 750);
      flash_span(t + 1, t + 2 * P);
      n_cyc = t + 173;
   endtask

   task automatic model_commit(input longint v);
      longint s;
      win.push_back(v);
      m_n++;
      if (win.size() > 16) s = win.pop_front();
      m_last = v;
      m_min  = (m_n == 1 || v < m_min) ? v : m_min;
      m_max  = (m_n == 1 || v > m_max) ? v : m_max;
      s = 0;
      foreach (win[i]) s += win[i];
      if (m_n >= 16) m_avg = s / 16;
      else if (m_n == 1 || m_n == 2 || m_n == 4 || m_n == 8) m_avg = s / m_n;
   endtask

   always @(negedge clock) begin
      if (active) begin
         if (exp_rv[cyc]) model_commit(longint'(lag_at[cyc]));
         chk("flash", flash, exp_flash[cyc]);
         chk("busy", busy, exp_busy[cyc]);
         chk("result_valid", result_valid, exp_rv[cyc]);
         chk("timeout", timeout, exp_to[cyc]);
         chk("last_lag", last_lag, m_last);
         chk("min_lag", min_lag, m_min);
         chk("max_lag", max_lag, m_max);
         chk("avg_lag", avg_lag, m_avg);
         chk("sample_count", sample_count, (m_n > 16) ? 16 : m_n);
         if (cyc == 250) chk("pin_flash_before_arm", flash, 0);
         if (cyc == 251) chk("pin_flash_rise", flash, 1);
         if (cyc == 417) begin
            chk("pin_first_rv", result_valid, 1);
            chk("pin_first_lag", last_lag, 102);
         end
         if (exp_rv[cyc]) begin
            case (m_n)
               1:  chk("pin_avg_n1", avg_lag, 102);
               2:  chk("pin_avg_n2", avg_lag, 152);
               3:  chk("pin_avg_n3_hold", avg_lag, 152);
               4:  chk("pin_avg_n4", avg_lag, 252);
               16: begin
                  chk("pin_min_n16", min_lag, 102);
                  chk("pin_max_n16", max_lag, 1602);
                  chk("pin_avg_n16", avg_lag, 852);
                  chk("pin_count_n16", sample_count, 16);
               end
               17: begin
                  chk("pin_avg_n17", avg_lag, 952);
                  chk("pin_max_n17", max_lag, 1702);
                  chk("pin_count_n17", sample_count, 16);
               end
               18: chk("pin_glitch_lag", last_lag, 302);
               default: ;
            endcase
         end
      end
   end

   initial begin
      reset       = 1'b0;
      enable      = 1'b0;
      frame_start = 1'b0;
      sensor      = 1'b0;
      active      = 1'b0;
      cyc         = 0;
      build_plan();
      if (n_cyc > MAXC - 1000) begin
         $display("FAIL plan_length: got %0d expected below %0d", n_cyc, MAXC - 1000);
         $fatal(1);
      end
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
      active = 1'b1;
      for (int c = 0; c < n_cyc; c++) begin
         cyc         = c;
         enable      = en_a[c];
         frame_start = (c % P == 0);
         sensor      = sraw[c];
         @(posedge clock);
         #1;
      end
      active      = 1'b0;
      cyc         = n_cyc;
      frame_start = 1'b0;
      // Mid-cycle while CONFIRM is debouncing: reset must act without a clock edge.
      #1 reset = 1'b0;
      #1;
      chk("rst_flash", flash, 0);
      chk("rst_busy", busy, 0);
      chk("rst_result_valid", result_valid, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_last_lag", last_lag, 0);
      chk("rst_min_lag", min_lag, ONES);
      chk("rst_max_lag", max_lag, 0);
      chk("rst_avg_lag", avg_lag, 0);
      chk("rst_sample_count", sample_count, 0);
      repeat (80) begin
         @(negedge clock);
         cyc++;
         chk("rst_hold_result_valid", result_valid, 0);
         chk("rst_hold_busy", busy, 0);
      end
      @(posedge clock);
      #1 reset = 1'b1;
      repeat (5) @(negedge clock);
      chk("post_rst_sample_count", sample_count, 0);
      chk("post_rst_last_lag", last_lag, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lag_measure_controller.md
# lag_measure_controller

Sequences a single display-lag measurement cycle in the lag tester and accumulates statistics. It sits between the video timing generator and the light sensor input: it tells the pattern generator when to flash the measurement field, times the interval from flash frame start to the sensor's rising edge in `clock` cycles, and reports last/min/max/average results. Runs in the `internal_clock` domain, alongside `video`.

## Interface
- `CNT_W`, 24: width of the latency counter and all result outputs.
- `TIMEOUT_CYCLES`, 24'd16_000_000: give-up limit for one measurement.
- `DARK_FRAMES`, 4: frames the sensor must read dark before arming.
- `FLASH_FRAMES`, 2: frames the flash field stays lit.
- `DEBOUNCE`, 64: cycles the synced sensor must stay high to count as a hit.
- `clock` in 1: measurement clock (`internal_clock`).
- `reset` in 1: asynchronous, active-low reset.
- `enable` in 1: level; 0 stops new measurements.
- `frame_start` in 1: one-cycle pulse at the first active pixel of each frame, from `video`.
- `sensor` in 1: raw, asynchronous photodiode comparator output.
- `flash` out 1: 1 tells `video` to draw white in the measurement field.
- `busy` out 1: high in every state except IDLE.
- `result_valid` out 1: one-cycle pulse when `last_lag` updates.
- `timeout` out 1: one-cycle pulse when a measurement is abandoned.
- `last_lag`, `min_lag`, `max_lag`, `avg_lag` out CNT_W: latency statistics in cycles.
- `sample_count` out 5: number of accepted samples, saturating at 16.

## Operation
- `sensor` passes through a 2-flop synchronizer (`sens_s`) before any use.
- **IDLE**: `flash`=0. If `enable`=1, go to DARK and clear the dark-frame count.
- **DARK**:
  - Count `frame_start` pulses while `sens_s`=0.
  - Any `sens_s`=1 clears the count.
  - When the count reaches DARK_FRAMES, go to ARM.
- **ARM**: on the next `frame_start`, clear the latency counter to 0, set `flash`=1, clear the flash-frame count, and go to MEASURE.
- **MEASURE**:
  - The counter increments every cycle.
  - `flash` drops after FLASH_FRAMES further `frame_start` pulses.
  - On the first cycle with `sens_s`=1, latch the candidate as the counter value and go to CONFIRM.
  - If the counter reaches TIMEOUT_CYCLES, pulse `timeout`, set `flash`=0, and go to DARK.
- **CONFIRM**:
  - The counter keeps running and the flash-frame countdown keeps running.
  - If `sens_s` falls before DEBOUNCE cycles have passed, discard the candidate and return to MEASURE (glitch).
  - After DEBOUNCE consecutive high cycles, commit the candidate, pulse `result_valid`, and go to COOLDOWN.
  - The timeout check still applies in CONFIRM.
- **COOLDOWN**: `flash`=0. Go to DARK; the next cycle begins.
- Commit on a valid result:
  - `last_lag` ← candidate.
  - `min_lag`/`max_lag` update by comparison; the first sample loads both.
  - A 16-entry sliding window feeds a running sum of width CNT_W+4: sum += new − oldest.
  - `avg_lag` = sum >> 4 once `sample_count`=16; before that, `avg_lag` = sum / `sample_count` using only power-of-2 counts (1, 2, 4, 8) and holds its value between them.
- `enable`=0 in any state: finish the current state only if it is CONFIRM; otherwise go straight to IDLE with `flash`=0. Statistics are retained.
- A `frame_start` coinciding with the ARM→MEASURE transition is the one consumed by ARM. It does not count as a flash frame.

## Timing
- Reset values:
  - State IDLE.
  - `flash`=0, `busy`=0, `result_valid`=0, `timeout`=0.
  - All results 0; `min_lag` = all-ones; `sample_count`=0.
  - Synchronizer flops 0.
- Counter is 0 in the cycle after the accepted `frame_start`.
- The reported lag includes the fixed 2-cycle synchronizer delay. No correction is applied; the downstream display applies it.
- `result_valid` asserts DEBOUNCE cycles after the first synced-high cycle. Statistics outputs are valid in that same cycle (registered).
- Reset asserted mid-measurement returns to IDLE asynchronously. The window contents are discarded.

## Structure
- Shared package `lagtester_pkg`:
  - `LagState` enum (IDLE, DARK, ARM, MEASURE, CONFIRM, COOLDOWN).
  - `LAG_CNT_W` constant.
- Sub-module `lag_stats`: min/max tracking, 16-deep sliding window, sum, average, and `sample_count`. It takes commit pulse plus value.
- The FSM and counters stay in `lag_measure_controller`.

## Test plan
- Sensor held low, `enable`=1, sensor goes high 50 000 cycles after the ARM frame_start for 1000 cycles → `last_lag`=50 002, `result_valid` pulses once, `flash` high for exactly 2 frames.
- Sensor glitch high for 10 cycles at 20 000, then solid high at 30 000 → `last_lag`=30 002; no result at 20 002.
- Sensor never rises → `timeout` pulses at counter=TIMEOUT_CYCLES, FSM back in DARK, results unchanged.
- Sensor high during DARK for 1 frame → arming delayed until 4 consecutive dark frames follow.
- 16 samples of 1000..16000 (step 1000) → `min_lag`=1002, `max_lag`=16 002, `avg_lag`=8502, `sample_count`=16. A 17th sample of 17 000 → `avg_lag`=9502.
- `reset` low during CONFIRM → all outputs at reset values immediately, no `result_valid`.
